// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver: segment vector
// type, the all-off pattern and the active-low gfedcba hex glyph table.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  // Index = nibble value; bit 6 = g ... bit 0 = a, a zero lights the segment.
  localparam seg_t HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic seg_t hexToSeg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

  // Select width for a count of items; never narrower than one bit.
  function automatic int selWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit nibble to active-low seven-segment glyph.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hexToSeg(nibble);

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scan driver: snapshots one page of dataIn per frame
// and scans it over DIGITS common-anode digits with a blank interval per slot.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading-zero digits.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter  int DIGITS    = 4,
  parameter  int PAGES     = 2,
  parameter  int SCAN_DIV  = 1024,
  parameter  int BLANK_CYC = 16,
  localparam int PSEL_W    = selWidth(PAGES)
) (
  input  logic                        clkin,
  input  logic                        reset,
  input  logic [4*DIGITS*PAGES-1:0]   dataIn,
  input  logic [DIGITS-1:0]           dpIn,
  input  logic [PSEL_W-1:0]           pageSel,
  output logic [DIGITS-1:0]           bitSel,
  output seg_t                        segSel,
  output logic                        dp,
  output logic                        frameTick
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int DIG_W  = selWidth(DIGITS);
  localparam int PAGE_W = 4 * DIGITS;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]  BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);

  logic [DIV_W-1:0]  divCnt;
  logic [DIG_W-1:0]  digIdx;
  logic [PAGE_W-1:0] shadow;
  logic [DIGITS-1:0] shadowDp;
  logic              slotEnd;
  logic              frameEnd;
  logic              snapTick;

  logic [PAGE_W-1:0] pageData;
  logic [DIGITS-1:0] digOneHot;
  logic [3:0]        curNib;
  logic              curDp;
  logic              curBlank;
  seg_t              decSeg;
  logic              litPhase;

  logic [DIGITS-1:0] bitSelNext;
  seg_t              segSelNext;
  logic              dpNext;

  assign slotEnd  = (divCnt == DIV_LAST);
  assign frameEnd = slotEnd && (digIdx == DIG_LAST);
  assign litPhase = (divCnt >= BLANK_END);

  // Slot and digit counters; with one digit digIdx never leaves 0.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      divCnt <= '0;
      digIdx <= '0;
    end else if (slotEnd) begin
      divCnt <= '0;
      digIdx <= (digIdx == DIG_LAST) ? '0 : digIdx + 1'b1;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

  // Page mux; an out-of-range select matches no page and falls back to page 0.
  always_comb begin
    pageData = dataIn[PAGE_W-1:0];
    for (int p = 1; p < PAGES; p++) begin
      if (pageSel == PSEL_W'(p)) pageData = dataIn[p*PAGE_W +: PAGE_W];
    end
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      shadow   <= '0;
      shadowDp <= '0;
    end else if (frameEnd) begin
      shadow   <= pageData;
      shadowDp <= dpIn;
    end
  end

  always_comb begin
    digOneHot = '0;
    curNib    = 4'h0;
    curDp     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digIdx == DIG_W'(i)) begin
        digOneHot[i] = 1'b1;
        curNib       = shadow[4*i +: 4];
        curDp        = shadowDp[i];
      end
    end
  end

  seg_hex_decode u_decode (
    .nibble (curNib),
    .seg    (decSeg)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Reset value matches the mask of the all-zero reset shadow.
  localparam logic [DIGITS-1:0] ZERO_MASK = ~DIGITS'(1);

  logic [DIGITS-1:0] blankMask;
  logic [DIGITS-1:0] blankMaskNext;
  logic              seenNz;

  // A digit is blanked when it and every digit above it are zero; digit 0 never.
  always_comb begin
    blankMaskNext = '0;
    seenNz        = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seenNz           = seenNz | (pageData[4*i +: 4] != 4'h0);
      blankMaskNext[i] = !seenNz;
    end
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      blankMask <= ZERO_MASK;
    end else if (frameEnd) begin
      blankMask <= blankMaskNext;
    end
  end

  assign curBlank = |(blankMask & digOneHot);
`else
  assign curBlank = 1'b0;
`endif

  always_comb begin
    bitSelNext = '1;
    segSelNext = SEG_OFF;
    dpNext     = 1'b1;
    if (litPhase) begin
      bitSelNext = ~digOneHot;
      segSelNext = curBlank ? SEG_OFF : decSeg;
      dpNext     = ~curDp;
    end
  end

  // snapTick marks the first cycle of the new shadow; frameTick is its registered copy.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      bitSel    <= '1;
      segSel    <= SEG_OFF;
      dp        <= 1'b1;
      snapTick  <= 1'b0;
      frameTick <= 1'b0;
    end else begin
      bitSel    <= bitSelNext;
      segSel    <= segSelNext;
      dp        <= dpNext;
      snapTick  <= frameEnd;
      frameTick <= snapTick;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (DIGITS=4, PAGES=2, SCAN_DIV=4, BLANK_CYC=1) with a
// frame-level reference model; honours SEG_LEADING_ZERO_BLANK_EN when defined.
module tb_seg_scan_mux;

  localparam int DIGITS    = 4;
  localparam int PAGES     = 2;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = DIGITS * SCAN_DIV;

  logic        clkin = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dataIn = '0;
  logic [3:0]  dpIn = '0;
  logic [0:0]  pageSel = '0;
  logic [3:0]  bitSel;
  logic [6:0]  segSel;
  logic        dp;
  logic        frameTick;

  int vecCnt  = 0;
  int missCnt = 0;
  int t       = 0;

  // Snapshot seen by frame f of the current run (frame 0 is the reset shadow).
  logic [15:0] snapPage [0:255];
  logic [3:0]  snapDp   [0:255];

  seg_scan_mux #(
    .DIGITS(DIGITS), .PAGES(PAGES), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clkin(clkin), .reset(reset), .dataIn(dataIn), .dpIn(dpIn),
    .pageSel(pageSel), .bitSel(bitSel), .segSel(segSel), .dp(dp),
    .frameTick(frameTick)
  );

  always #5 clkin = ~clkin;

  function automatic logic [6:0] hexSeg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Outputs in cycle t describe slot position t-1 of the current run.
  task automatic checkCycle();
    logic [3:0]  eb;
    logic [6:0]  es;
    logic        ed;
    logic        ef;
    logic [15:0] pg;
    int s, dc, di, f, hi;
    eb = 4'hF; es = 7'h7F; ed = 1'b1; ef = 1'b0;
    if (t >= 1) begin
      s  = t - 1;
      dc = s % SCAN_DIV;
      di = (s / SCAN_DIV) % DIGITS;
      f  = s / FRAME;
      pg = snapPage[f];
      if (dc >= BLANK_CYC) begin
        eb     = 4'hF;
        eb[di] = 1'b0;
        es     = hexSeg(pg[4*di +: 4]);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        hi = 0;
        for (int k = 0; k < DIGITS; k++) if (pg[4*k +: 4] != 4'h0) hi = k;
        if (di > hi) es = 7'h7F;
`endif
        ed = ~snapDp[f][di];
      end
    end
    if (t >= 2 && ((t - 2) % FRAME) == FRAME - 1) ef = 1'b1;
    vecCnt++;
    if ({bitSel, segSel, dp, frameTick} !== {eb, es, ed, ef}) begin
      missCnt++;
      $display("FAIL model cycle %0d: got bitSel=%b segSel=%b dp=%b frameTick=%b, want bitSel=%b segSel=%b dp=%b frameTick=%b",
               t, bitSel, segSel, dp, frameTick, eb, es, ed, ef);
    end
  endtask

  task automatic expVal(input string nm, input logic [15:0] got, input logic [15:0] want);
    vecCnt++;
    if (got !== want) begin
      missCnt++;
      $display("FAIL %s at cycle %0d: got %b, want %b", nm, t, got, want);
    end
  endtask

  // Drive the inputs for the current cycle and record them if this is a frame boundary.
  task automatic applyIn(input logic [31:0] d, input logic [3:0] dv, input logic pg);
    dataIn  = d;
    dpIn    = dv;
    pageSel = pg;
    if ((t % FRAME) == FRAME - 1) begin
      snapPage[t / FRAME + 1] = dataIn[16*pageSel +: 16];
      snapDp[t / FRAME + 1]   = dpIn;
    end
    t++;
  endtask

  task automatic nextCycle();
    @(negedge clkin);
    checkCycle();
  endtask

  task automatic startRun();
    @(negedge clkin);
    reset       = 1'b1;
    t           = 0;
    snapPage[0] = '0;
    snapDp[0]   = '0;
    checkCycle();
  endtask

  initial begin
    logic [31:0] rd;
    int guard;
    repeat (3) @(negedge clkin);
    expVal("reset_dark", {5'b0, bitSel, segSel}, {5'b0, 4'b1111, 7'b1111111});
    expVal("reset_dp_tick", {14'b0, dp, frameTick}, {14'b0, 1'b1, 1'b0});

    // Fixed data, page 0, then page 1 selected mid-frame 2.
    startRun();
    applyIn(32'h1234_ABCD, 4'b0101, 1'b0);
    while (t < 64) begin
      nextCycle();
      case (t)
        1:  expVal("c1_blank",   {12'b0, bitSel}, {12'b0, 4'b1111});
        2:  expVal("c2_first",   {5'b0, bitSel, segSel}, {5'b0, 4'b1110, 7'b1000000});
        5:  expVal("slot_blank", {12'b0, bitSel}, {12'b0, 4'b1111});
        16: expVal("tick_c16",   {15'b0, frameTick}, 16'd0);
        17: expVal("tick_c17",   {15'b0, frameTick}, 16'd1);
        18: expVal("f1_dig0_d",  {4'b0, bitSel, segSel, dp}, {4'b0, 4'b1110, 7'b0100001, 1'b0});
        22: expVal("f1_dig1_C",  {4'b0, bitSel, segSel, dp}, {4'b0, 4'b1101, 7'b1000110, 1'b1});
        26: expVal("f1_dig2_b",  {5'b0, bitSel, segSel}, {5'b0, 4'b1011, 7'b0000011});
        30: expVal("f1_dig3_A",  {5'b0, bitSel, segSel}, {5'b0, 4'b0111, 7'b0001000});
        42: expVal("nontear_b",  {9'b0, segSel}, {9'b0, 7'b0000011});
        50: expVal("page1_dig0", {9'b0, segSel}, {9'b0, 7'b0011001});
        62: expVal("page1_dig3", {9'b0, segSel}, {9'b0, 7'b1111001});
        default: ;
      endcase
      applyIn(32'h1234_ABCD, 4'b0101, (t >= 38) ? 1'b1 : 1'b0);
    end

    // Random data, decimal points and page selects every cycle.
    while (t < 400) begin
      nextCycle();
      rd = $urandom;
      if ($urandom_range(0, 3) == 0) rd[15:0] = 16'h0 | 16'($urandom_range(0, 255));
      applyIn(rd, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // Run on to the middle of a digit-2 lit phase, then reset asynchronously.
    guard = 0;
    while (!(((t / SCAN_DIV) % DIGITS) == 2 && (t % SCAN_DIV) == 2) && guard < 64) begin
      nextCycle();
      applyIn($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      guard++;
    end
    @(negedge clkin);
    checkCycle();
    expVal("pre_reset_lit", {12'b0, bitSel}, {12'b0, 4'b1011});
    #2 reset = 1'b0;
    #1;
    expVal("async_dark", {4'b0, bitSel, segSel, dp}, {4'b0, 4'b1111, 7'b1111111, 1'b1});
    expVal("async_tick", {15'b0, frameTick}, 16'd0);
    repeat (2) @(negedge clkin);
    expVal("held_dark", {5'b0, bitSel, segSel}, {5'b0, 4'b1111, 7'b1111111});

    // Restart with a leading-zero page value.
    startRun();
    applyIn({16'h9999, 16'h0050}, 4'b0010, 1'b0);
    while (t < 40) begin
      nextCycle();
      case (t)
        2:  expVal("restart_dig0", {5'b0, bitSel, segSel}, {5'b0, 4'b1110, 7'b1000000});
        18: expVal("lz_dig0", {5'b0, bitSel, segSel}, {5'b0, 4'b1110, 7'b1000000});
        22: expVal("lz_dig1", {4'b0, bitSel, segSel, dp}, {4'b0, 4'b1101, 7'b0010010, 1'b0});
`ifdef SEG_LEADING_ZERO_BLANK_EN
        26: expVal("lz_dig2", {5'b0, bitSel, segSel}, {5'b0, 4'b1011, 7'b1111111});
        30: expVal("lz_dig3", {5'b0, bitSel, segSel}, {5'b0, 4'b0111, 7'b1111111});
`else
        26: expVal("lz_dig2", {5'b0, bitSel, segSel}, {5'b0, 4'b1011, 7'b1000000});
        30: expVal("lz_dig3", {5'b0, bitSel, segSel}, {5'b0, 4'b0111, 7'b1000000});
`endif
        default: ;
      endcase
      applyIn({16'h9999, 16'h0050}, 4'b0010, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised multiplexed seven-segment scan driver for the CPU board display. Takes a multi-page packed hex value from the datapath, such as the ALU result and HI/LO registers, and snapshots one page per display frame. It time-multiplexes the snapshot over `DIGITS` common-anode digits with a configurable per-digit dwell time and an anti-ghosting blank interval. It replaces the fixed 4-digit, two-page display logic and runs from the display clock.

## Interface
- `DIGITS`, 4: number of digits; legal 1..8.
- `PAGES`, 2: number of selectable data pages; legal 1..8.
- `SCAN_DIV`, 1024: clock cycles per digit slot; ≥ 2.
- `BLANK_CYC`, 16: cycles at the start of each slot with all digits off; must be < `SCAN_DIV`.

- `clkin`, input, 1: display clock; all state on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `dataIn`, input, 4*DIGITS*PAGES: packed nibbles. Page p occupies bits [4*DIGITS*(p+1)-1 : 4*DIGITS*p]. Digit 0 is the LS nibble of a page.
- `dpIn`, input, DIGITS: decimal-point request per digit, active-high.
- `pageSel`, input, clog2(PAGES) (min 1): page to display.
- `bitSel`, output, DIGITS: digit enables, active-low one-hot.
- `segSel`, output, 7: segments, active-low, bit 6 = g … bit 0 = a.
- `dp`, output, 1: decimal point, active-low.
- `frameTick`, output, 1: one-cycle pulse when a new snapshot takes effect.

## Operation
- `divCnt` counts 0..SCAN_DIV-1 and wraps.
- `digIdx` increments when `divCnt == SCAN_DIV-1` and wraps DIGITS-1 → 0.
- Frame boundary: `divCnt == SCAN_DIV-1 && digIdx == DIGITS-1`.
- At the frame boundary, the shadow register loads page `pageSel` of `dataIn` plus `dpIn`.
  - `pageSel` and `dataIn` are sampled only at the boundary. Mid-frame changes never tear the display.
  - An out-of-range `pageSel` (≥ PAGES) selects page 0.
- Blank slot phase, `divCnt < BLANK_CYC`: `bitSel`, `segSel` and `dp` are all ones.
- Lit slot phase:
  - `bitSel[digIdx] = 0`, all other bits 1.
  - `segSel` is the hex decode of shadow nibble `digIdx`.
  - `dp = ~shadowDp[digIdx]`.
- Hex decode (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- `DIGITS == 1`: `digIdx` stays 0, and every slot end is a frame boundary.

## Timing
- Reset values:
  - Counters and shadow are 0.
  - `bitSel` all ones, `segSel` 7'b1111111, `dp` 1, `frameTick` 0.
- Reset acts immediately, asynchronously, including mid-frame. Outputs go dark in the same instant.
- Outputs are registered. The outputs in cycle t+1 reflect counter and shadow state in cycle t (latency 1).
- The first active cycle after reset release has `divCnt = 0`, `digIdx = 0`.
  - The first slot is blank for BLANK_CYC cycles, then digit 0 shows shadow = 0, i.e. "0".
- The new shadow is visible from the first lit cycle of the next digit-0 slot.
- `frameTick` is high exactly one cycle: the cycle after the boundary.
- Frame period is DIGITS*SCAN_DIV cycles.
- Each digit is lit for SCAN_DIV-BLANK_CYC cycles per frame.

## Configuration
- `SEG_LEADING_ZERO_BLANK_EN` defined:
  - At each snapshot, a blank mask register is computed.
  - Digits above the highest nonzero nibble are blanked: `segSel` = 1111111, `bitSel` still asserted.
  - `dp` still follows `dpIn`.
  - Digit 0 is never blanked. A value of 0 shows a single "0".
- Not defined: all digits always show their nibble, and the mask logic is absent.

## Structure
- Shared package `seg_pkg`:
  - `SEG_OFF` (7'b1111111).
  - `seg_t` typedef (logic [6:0]).
  - Hex-to-segment constant table.
- One sub-module, `seg_hex_decode`: 4-bit nibble → `seg_t`, purely combinational.
- The top holds the counters, shadow, mask and output registers.

## Test plan
All scenarios use DIGITS=4, PAGES=2, SCAN_DIV=4, BLANK_CYC=1.
- Reset held, then released → outputs all ones; first lit cycle (cycle 2) has `bitSel` 1110 and `segSel` 1000000.
- `dataIn` = 32'h1234_ABCD, `pageSel` = 0, run 2 frames → `frameTick` at cycle 17. Second frame shows:
  - digit 0 `segSel` 0100001 (d)
  - digit 1 1000110 (C)
  - digit 2 0000011 (b)
  - digit 3 0001000 (A)
- Same data, `pageSel` toggled to 1 mid-frame → current frame unchanged; next frame shows 4, 3, 2, 1 on digits 0..3, e.g. digit 0 `segSel` 0011001.
- Every slot, cycle 0 → `bitSel` 1111; cycles 1–3 → exactly one zero bit, with no overlap between adjacent digits.
- `reset` pulsed low during digit 2 → outputs dark asynchronously; the scan restarts at digit 0 with shadow 0.
- `SEG_LEADING_ZERO_BLANK_EN` with page value 16'h0050 → digits 3 and 2 show `segSel` 1111111, digit 1 shows 0010010, digit 0 shows 1000000.
